// File: rtl/jt89_mixn.sv
// jt89_mixn: sequential gain/mute mixer, one channel per clock.
// Optional DC blocker on the output: define JT89_MIXN_DCBLOCK_EN.
module jt89_mixn #(
  parameter int bw = 9,
  parameter int CH = 4,
  parameter int GW = 4,
  parameter int OW = bw + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic [CH*bw-1:0]   ch,
  input  logic [CH*GW-1:0]   gain,
  input  logic [CH-1:0]      mute,
  output logic [OW-1:0]      sound,
  output logic               sample,
  output logic               busy,
  output logic               sat,
  output logic               overrun
);

  localparam int AW = bw + GW + $clog2(CH) + 1;
  localparam int PW = bw + GW + 1;
  localparam int CW = $clog2(CH);
  localparam logic signed [AW-1:0] HI =
    AW'((1 << (OW - 1)) - 1);
  localparam logic signed [AW-1:0] LO = ~HI;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SAT
  } state_t;

  state_t st, st_nx;
  logic [CW-1:0] cnt;
  logic [CH*bw-1:0] ch_s;
  logic [CH*GW-1:0] gain_s;
  logic [CH-1:0] mute_s;
  logic signed [AW-1:0] acc;
  logic start, step, fin;

  logic [bw-1:0] chv;
  logic [GW-1:0] gv;
  logic signed [PW-1:0] cx, gx, prod, term;
  logic signed [AW-1:0] addend;
  logic signed [OW-1:0] res;
  logic clip;

  assign busy = (st != IDLE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  // next state and per-state strobes
  always_comb begin
    st_nx = st;
    start = 1'b0;
    step  = 1'b0;
    fin   = 1'b0;
    unique case (st)
      IDLE: begin
        if (cen) begin
          start = 1'b1;
          st_nx = ACC;
        end
      end
      ACC: begin
        step = 1'b1;
        if (cnt == CW'(CH - 1)) st_nx = SAT;
      end
      SAT: begin
        fin   = 1'b1;
        st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  // current channel term: floor(ch * gain / unity)
  always_comb begin
    chv  = ch_s[cnt*bw +: bw];
    gv   = gain_s[cnt*GW +: GW];
    cx   = {{(PW-bw){chv[bw-1]}}, chv};
    gx   = {{(PW-GW){1'b0}}, gv};
    prod = cx * gx;
    term = prod >>> (GW - 1);
    if (mute_s[cnt]) addend = '0;
    else addend = {{(AW-PW){term[PW-1]}}, term};
  end

  // clamp the finished sum to the output range
  always_comb begin
    res  = acc[OW-1:0];
    clip = 1'b0;
    if (acc > HI) begin
      res  = HI[OW-1:0];
      clip = 1'b1;
    end else if (acc < LO) begin
      res  = LO[OW-1:0];
      clip = 1'b1;
    end
  end

  // snapshot, accumulate and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_s    <= '0;
      gain_s  <= '0;
      mute_s  <= '0;
      acc     <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      if (start) begin
        ch_s   <= ch;
        gain_s <= gain;
        mute_s <= mute;
        acc    <= '0;
        cnt    <= '0;
      end else if (step) begin
        acc <= acc + addend;
        cnt <= cnt + CW'(1);
      end
      if (cen && st != IDLE) overrun <= 1'b1;
    end
  end

`ifdef JT89_MIXN_DCBLOCK_EN
  localparam int DW = OW + 3;
  localparam logic signed [DW-1:0] YHI =
    DW'((1 << (OW - 1)) - 1);
  localparam logic signed [DW-1:0] YLO = ~YHI;

  logic signed [OW-1:0] xr, xp, yp, yc;
  logic signed [DW-1:0] yf;
  logic xs, vld, yclip;

  // high-pass: y = x - x_prev + y_prev - y_prev/256
  always_comb begin
    yf = DW'(xr) - DW'(xp) + DW'(yp)
       - (DW'(yp) >>> 8);
    yc    = yf[OW-1:0];
    yclip = 1'b0;
    if (yf > YHI) begin
      yc    = YHI[OW-1:0];
      yclip = 1'b1;
    end else if (yf < YLO) begin
      yc    = YLO[OW-1:0];
      yclip = 1'b1;
    end
  end

  // mix result stage, then blocker output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr     <= '0;
      xs     <= 1'b0;
      vld    <= 1'b0;
      xp     <= '0;
      yp     <= '0;
      sound  <= '0;
      sat    <= 1'b0;
      sample <= 1'b0;
    end else begin
      vld    <= fin;
      sample <= vld;
      if (fin) begin
        xr <= res;
        xs <= clip;
      end
      if (vld) begin
        sound <= yc;
        sat   <= xs | yclip;
        xp    <= xr;
        yp    <= yc;
      end
    end
  end
`else
  // register the clamped result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sound  <= '0;
      sat    <= 1'b0;
      sample <= 1'b0;
    end else begin
      sample <= fin;
      if (fin) begin
        sound <= res;
        sat   <= clip;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jt89_mixn.sv
// tb_jt89_mixn: vector table plus scoreboard bench
// for jt89_mixn at default parameters.
module tb_jt89_mixn;

  localparam int BW = 9;
  localparam int NC = 4;
  localparam int GW = 4;
  localparam int OW = 11;
`ifdef JT89_MIXN_DCBLOCK_EN
  localparam int LAT = NC + 3;
`else
  localparam int LAT = NC + 2;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cen;
  logic [NC*BW-1:0] ch_i;
  logic [NC*GW-1:0] gain_i;
  logic [NC-1:0] mute_i;
  logic [OW-1:0] sound;
  logic sample, busy, sat, overrun;

  jt89_mixn dut (
    .clk(clk),
    .rst(rst),
    .cen(cen),
    .ch(ch_i),
    .gain(gain_i),
    .mute(mute_i),
    .sound(sound),
    .sample(sample),
    .busy(busy),
    .sat(sat),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int snd;
    int st;
    int t0;
  } exp_t;

  typedef struct {
    logic [NC*BW-1:0] c;
    logic [NC*GW-1:0] g;
    logic [NC-1:0] m;
    int snd;
    int st;
  } vec_t;

  exp_t q[$];
  exp_t me;
  vec_t tbl[10];
  int checks = 0;
  int fails = 0;
  int last = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  function automatic logic [NC*BW-1:0] pk(
    input int a, input int b,
    input int c, input int d);
    return {d[BW-1:0], c[BW-1:0],
            b[BW-1:0], a[BW-1:0]};
  endfunction

  function automatic logic [NC*GW-1:0] pg(
    input int a, input int b,
    input int c, input int d);
    return {d[GW-1:0], c[GW-1:0],
            b[GW-1:0], a[GW-1:0]};
  endfunction

  function automatic int model(
    input logic [NC*BW-1:0] c,
    input logic [NC*GW-1:0] g,
    input logic [NC-1:0] m,
    output int st);
    int s, x, gg;
    s = 0;
    for (int k = 0; k < NC; k++) begin
      x  = int'($signed(c[k*BW +: BW]));
      gg = int'(g[k*GW +: GW]);
      if (!m[k]) s += (x * gg) >>> (GW - 1);
    end
    st = 0;
    if (s > 1023) begin s = 1023; st = 1; end
    if (s < -1024) begin s = -1024; st = 1; end
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst && sample) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious_sample sound=%0d",
                 $signed(sound));
      end else begin
        me = q.pop_front();
        chk("sound", $signed(sound), me.snd);
        chk("sat", sat, me.st);
        chk("latency", cyc - me.t0, LAT);
        last = me.snd;
      end
    end
  end

  task automatic push(input int snd, input int st);
    exp_t e;
    e.snd = snd;
    e.st  = st;
    e.t0  = cyc;
    q.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("sample_timeout", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("sound_hold", $signed(sound), last);
  endtask

  task automatic mix(input logic [NC*BW-1:0] c,
                     input logic [NC*GW-1:0] g,
                     input logic [NC-1:0] m,
                     input int snd,
                     input int st);
    logic [63:0] r;
    @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    ch_i   = c;
    gain_i = g;
    mute_i = m;
    cen    = 1'b1;
    push(snd, st);
    @(posedge clk);
    #1;
    cen = 1'b0;
    r = {$urandom(), $urandom()};
    ch_i   = r[NC*BW-1:0];
    gain_i = r[NC*GW-1:0];
    mute_i = r[63:60];
    chk("busy", busy, 1);
    wait_done();
  endtask

  initial begin
    int s, st;
    int xp, yp, y;
    logic [NC*BW-1:0] rc;
    logic [NC*GW-1:0] rg;
    logic [NC-1:0] rm;

    tbl[0] = '{pk(100,100,100,100), pg(8,8,8,8),
               4'b0000, 400, 0};
    tbl[1] = '{pk(255,255,255,255), pg(15,15,15,15),
               4'b0000, 1023, 1};
    tbl[2] = '{pk(-256,-256,-256,-256),
               pg(15,15,15,15), 4'b0000, -1024, 1};
    tbl[3] = '{pk(100,0,0,0), pg(8,8,8,8),
               4'b0001, 0, 0};
    tbl[4] = '{pk(100,0,0,0), pg(8,8,8,8),
               4'b0000, 100, 0};
    tbl[5] = '{pk(-5,7,0,3), pg(1,2,3,4),
               4'b0000, 1, 0};
    tbl[6] = '{pk(255,255,255,230), pg(8,8,8,9),
               4'b0000, 1023, 0};
    tbl[7] = '{pk(-256,-256,-256,-256), pg(8,8,8,8),
               4'b0000, -1024, 0};
    tbl[8] = '{pk(255,255,255,255), pg(15,15,15,15),
               4'b1111, 0, 0};
    tbl[9] = '{pk(-256,-256,-256,-256), pg(0,0,0,0),
               4'b0000, 0, 0};

    rst    = 1'b1;
    cen    = 1'b0;
    ch_i   = '0;
    gain_i = '0;
    mute_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sound", $signed(sound), 0);
    chk("rst_sample", sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;

`ifdef JT89_MIXN_DCBLOCK_EN
    xp = 0;
    yp = 0;
    for (int i = 0; i < 5; i++) begin
      y = 400 - xp + yp - (yp >>> 8);
      mix(pk(100,100,100,100), pg(8,8,8,8),
          4'b0000, y, 0);
      xp = 400;
      yp = y;
    end
`else
    for (int i = 0; i < 10; i++) begin
      mix(tbl[i].c, tbl[i].g, tbl[i].m,
          tbl[i].snd, tbl[i].st);
      chk("no_overrun", overrun, 0);
    end

    for (int i = 0; i < 4; i++) begin
      rc = {$urandom(), $urandom()};
      rg = 16'($urandom());
      rm = 4'($urandom());
      s = model(rc, rg, rm, st);
      mix(rc, rg, rm, s, st);
    end

    @(posedge clk);
    #1;
    ch_i   = pk(10,20,30,40);
    gain_i = pg(8,8,8,8);
    mute_i = '0;
    cen    = 1'b1;
    push(100, 0);
    @(posedge clk);
    #1;
    cen  = 1'b0;
    ch_i = pk(-1,-1,-1,-1);
    @(posedge clk);
    #1;
    cen = 1'b1;
    @(posedge clk);
    #1;
    cen = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_done();
    repeat (8) @(posedge clk);
    #1;
    chk("overrun_sticky", overrun, 1);
    mix(pk(255,255,255,255), pg(15,15,15,15),
        4'b0000, 1023, 1);
    chk("overrun_kept", overrun, 1);

    @(posedge clk);
    #1;
    ch_i   = pk(50,50,50,50);
    gain_i = pg(8,8,8,8);
    mute_i = '0;
    cen    = 1'b1;
    push(200, 0);
    @(posedge clk);
    #1;
    cen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("acc_busy", busy, 1);
    rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_sound", $signed(sound), 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sample", sample, 0);
    chk("mid_rst_sat", sat, 0);
    chk("mid_rst_overrun", overrun, 0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    last = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_sound", $signed(sound), 0);
    mix(pk(-30,60,-90,120), pg(8,8,8,8),
        4'b0000, 60, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jt89_mixn.md
JT89_MIXN -- requirements
Module: jt89_mixn

Interface
REQ-001 SHALL have parameter bw, default 9, giving the signed channel sample width.
REQ-002 SHALL have parameter CH, default 4, giving the channel count; legal range is 2..16.
REQ-003 SHALL have parameter GW, default 4, giving the unsigned per-channel gain width; gain 2^(GW-1) is unity.
REQ-004 SHALL have parameter OW, default bw+2, giving the signed output width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port cen, input, 1 bit: sample strobe that requests one mix.
REQ-008 SHALL have port ch, input, CH*bw bits: signed channel samples; channel k sits at bits [k*bw +: bw].
REQ-009 SHALL have port gain, input, CH*GW bits: unsigned gains; channel k sits at bits [k*GW +: GW].
REQ-010 SHALL have port mute, input, CH bits: a 1 in bit k forces channel k's contribution to 0.
REQ-011 SHALL have port sound, output, OW bits: signed, saturated mix result.
REQ-012 SHALL have port sample, output, 1 bit: one-cycle pulse marking the cycle sound updates.
REQ-013 SHALL have port busy, output, 1 bit: high while a mix is in progress.
REQ-014 SHALL have port sat, output, 1 bit: high when the last result was clipped; updates with sample.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag set when cen arrives while busy.

Function
REQ-016 SHALL implement an FSM with states IDLE, ACC and SAT.
- IDLE -> ACC on cen.
- ACC holds for exactly CH cycles.
- SAT lasts 1 cycle, then returns to IDLE.
REQ-017 SHALL, on cen in IDLE, capture ch, gain and mute into snapshot registers and clear the accumulator; later input changes do not affect that mix.
REQ-018 SHALL, in ACC, process one channel per cycle in index order 0..CH-1 using a channel counter that resets to 0 on each mix start:
- p = signed ch_k * {1'b0, gain_k}, width bw+GW+1;
- term = p >>> (GW-1), arithmetic shift, i.e. floor;
- accumulator += (mute_k ? 0 : term).
REQ-019 SHALL size the accumulator at bw+GW+clog2(CH)+1 bits so that it never wraps internally.
REQ-020 SHALL, in SAT, clamp the accumulator to [-2^(OW-1), 2^(OW-1)-1], register the result to sound, set sat if clamping occurred, and pulse sample.
REQ-021 SHALL give a latency of CH+2 clk cycles from the cen edge in IDLE to the sample pulse.
REQ-022 SHALL hold busy high from the cycle after cen through the SAT cycle inclusive.
REQ-023 SHALL ignore cen while busy (no restart) and set overrun; overrun is cleared only by reset.
REQ-024 SHALL start a new mix when cen coincides with the SAT cycle's return to IDLE only on the following cen; a cen during SAT counts as overrun.
REQ-025 SHALL hold sound and sat between sample pulses.
REQ-026 SHALL, with every gain equal to 2^(GW-1) and mute=0, produce a sound equal to the plain sum of the sign-extended channels (legacy-compatible).

Reset
REQ-027 SHALL, while rst is high, force FSM=IDLE, sound=0, sample=0, busy=0, sat=0, overrun=0, accumulator=0 and counter=0, at any time including mid-ACC.
REQ-028 SHALL, after rst falls, ignore the mix that was aborted; the first sample pulse comes from a fresh cen.

Configuration
REQ-029 SHALL, when macro JT89_MIXN_DCBLOCK_EN is defined, insert a registered DC blocker between SAT and sound:
- y = x - x_prev + y_prev - (y_prev >>> 8);
- y is saturated to OW bits;
- state resets to 0;
- latency becomes CH+3 cycles.
REQ-030 SHALL, without JT89_MIXN_DCBLOCK_EN, include no DC-blocker logic and keep a latency of CH+2 cycles.

Verification (defaults bw=9, CH=4, GW=4, OW=11, macro undefined)
REQ-031 SHALL cover: all ch=100, gains=8, mute=0, one cen -> sample pulse 6 cycles later, sound=400, sat=0.
REQ-032 SHALL cover: all ch=255, gains=15 -> each term 478, sum 1912 -> sound=1023, sat=1; all ch=-256, gains=15 -> sound=-1024, sat=1.
REQ-033 SHALL cover: ch0=100, others 0, gains=8, mute=4'b0001 -> sound=0; mute=0 -> sound=100.
REQ-034 SHALL cover: second cen 2 cycles after the first -> only one sample pulse, result from the first snapshot, overrun=1 until rst.
REQ-035 SHALL cover: rst asserted in the 3rd ACC cycle -> sound=0, busy=0, no sample pulse; the next cen gives a correct result after 6 cycles.
REQ-036 SHALL cover: macro defined, constant ch=100 on all channels, gains=8, repeated cen -> first output 400, then decaying toward 0, latency 7 cycles.
